spike_window_classifier: RTL and testbench



---
 rtl/spike_window_classifier_if.sv | 27 ++
 rtl/spike_window_classifier.sv | 152 +++++++++++++++
 tb/tb_spike_window_classifier.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_window_classifier_if.sv
// Result channel of the spike window classifier: one window result per
// valid/ready transfer, plus the sticky overrun flag.
interface spike_window_classifier_if #(
    parameter int COUNT_W = 16
);
    logic               valid_o;
    logic               ready_i;
    logic [COUNT_W-1:0] count_o;
    logic [1:0]         class_o;
    logic               overrun_o;

    modport master (
        output valid_o,
        output count_o,
        output class_o,
        output overrun_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  count_o,
        input  class_o,
        input  overrun_o,
        output ready_i
    );
endinterface

// File: rtl/spike_window_classifier.sv
// Counts rising edges of the network output spike over fixed windows and
// publishes a LOW/NORMAL/HIGH/ERROR classification of each window count.
module spike_window_classifier #(
    parameter int WINDOW_CYCLES = 1200000,
    parameter int COUNT_W       = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         spike_i,
    input  logic                         en_i,
    input  logic [COUNT_W-1:0]           lo_thr_i,
    input  logic [COUNT_W-1:0]           hi_thr_i,
    spike_window_classifier_if.master    res
);

    localparam int                 WIN_W    = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

    localparam logic [1:0] CLS_LOW    = 2'd0;
    localparam logic [1:0] CLS_NORMAL = 2'd1;
    localparam logic [1:0] CLS_HIGH   = 2'd2;
    localparam logic [1:0] CLS_ERROR  = 2'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [WIN_W-1:0]   win_cnt_r;
    logic [WIN_W-1:0]   win_cnt_s;
    logic [COUNT_W-1:0] spike_cnt_r;
    logic [COUNT_W-1:0] spike_cnt_s;
    logic [COUNT_W-1:0] cnt_next_s;
    logic               spike_d_r;
    logic               edge_s;
    logic               terminal_s;

    logic               valid_r;
    logic [COUNT_W-1:0] count_r;
    logic [1:0]         class_r;
    logic               overrun_r;

    // Inverted threshold pair is reported as ERROR before any count comparison.
    function automatic logic [1:0] classify(
        input logic [COUNT_W-1:0] cnt,
        input logic [COUNT_W-1:0] lo,
        input logic [COUNT_W-1:0] hi
    );
        logic [1:0] cls;
        if (lo > hi) begin
            cls = CLS_ERROR;
        end else if (cnt < lo) begin
            cls = CLS_LOW;
        end else if (cnt > hi) begin
            cls = CLS_HIGH;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

    assign edge_s     = spike_i & ~spike_d_r;
    assign cnt_next_s = (edge_s && (spike_cnt_r != CNT_MAX)) ? spike_cnt_r + {{(COUNT_W-1){1'b0}}, 1'b1}
                                                              : spike_cnt_r;
    assign terminal_s = (state_r == COUNT) && (win_cnt_r == {WIN_W{1'b0}});

    // Next-state and window/spike counter logic.
    always_comb begin
        state_s     = state_r;
        win_cnt_s   = win_cnt_r;
        spike_cnt_s = spike_cnt_r;
        case (state_r)
            IDLE: begin
                spike_cnt_s = {COUNT_W{1'b0}};
                if (en_i) begin
                    state_s   = COUNT;
                    win_cnt_s = WIN_LAST;
                end else begin
                    state_s   = IDLE;
                end
            end
            COUNT: begin
                if (win_cnt_r == {WIN_W{1'b0}}) begin
                    win_cnt_s   = WIN_LAST;
                    spike_cnt_s = {COUNT_W{1'b0}};
                    state_s     = en_i ? COUNT : IDLE;
                end else if (!en_i) begin
                    // Abort: the partial window never reaches the result registers.
                    state_s     = IDLE;
                    win_cnt_s   = WIN_LAST;
                    spike_cnt_s = {COUNT_W{1'b0}};
                end else begin
                    state_s     = COUNT;
                    win_cnt_s   = win_cnt_r - WIN_W'(1);
                    spike_cnt_s = cnt_next_s;
                end
            end
            default: begin
                state_s     = IDLE;
                win_cnt_s   = WIN_LAST;
                spike_cnt_s = {COUNT_W{1'b0}};
            end
        endcase
    end

    // State, counters and spike history register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            win_cnt_r   <= {WIN_W{1'b0}};
            spike_cnt_r <= {COUNT_W{1'b0}};
            spike_d_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            win_cnt_r   <= win_cnt_s;
            spike_cnt_r <= spike_cnt_s;
            spike_d_r   <= spike_i;
        end
    end

    // Result registers and valid/ready handshake with sticky overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_r   <= 1'b0;
            count_r   <= {COUNT_W{1'b0}};
            class_r   <= CLS_LOW;
            overrun_r <= 1'b0;
        end else if (terminal_s) begin
            valid_r <= 1'b1;
            count_r <= cnt_next_s;
            class_r <= classify(cnt_next_s, lo_thr_i, hi_thr_i);
            if (valid_r && !res.ready_i) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (valid_r && res.ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign res.valid_o   = valid_r;
    assign res.count_o   = count_r;
    assign res.class_o   = class_r;
    assign res.overrun_o = overrun_r;

endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed self-checking bench: DUT a uses 8-cycle windows, DUT b uses
// 40-cycle windows to exercise counter saturation.
module tb_spike_window_classifier;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       spike_i = 1'b0;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic [3:0] lo_thr = 4'd0;
    logic [3:0] hi_thr = 4'd0;

    int checks = 0;
    int errors = 0;

    spike_window_classifier_if #(.COUNT_W(4)) res_a ();
    spike_window_classifier_if #(.COUNT_W(4)) res_b ();

    spike_window_classifier #(.WINDOW_CYCLES(8), .COUNT_W(4)) dut_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .spike_i  (spike_i),
        .en_i     (en_a),
        .lo_thr_i (lo_thr),
        .hi_thr_i (hi_thr),
        .res      (res_a)
    );

    spike_window_classifier #(.WINDOW_CYCLES(40), .COUNT_W(4)) dut_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .spike_i  (spike_i),
        .en_i     (en_b),
        .lo_thr_i (lo_thr),
        .hi_thr_i (hi_thr),
        .res      (res_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        en_a  = 1'b0;
        en_b  = 1'b0;
        res_a.ready_i = 1'b0;
        res_b.ready_i = 1'b0;
        spike_i = 1'b1;
        tick(1);
        spike_i = 1'b0;
        tick(1);
        rst_i = 1'b0;
    endtask

    task automatic start_a();
        en_a = 1'b1;
        tick(1);
    endtask

    // One full window of DUT a; terminal-cycle ready and thresholds given separately.
    task automatic drive_window(input logic [7:0] pat, input logic rdy_last,
                                input logic [3:0] lo_last, input logic [3:0] hi_last);
        for (int i = 0; i < 8; i++) begin
            spike_i = pat[i];
            if (i == 7) begin
                res_a.ready_i = rdy_last;
                lo_thr = lo_last;
                hi_thr = hi_last;
            end
            tick(1);
        end
        res_a.ready_i = 1'b0;
        spike_i = 1'b0;
    endtask

    task automatic consume_a();
        res_a.ready_i = 1'b1;
        en_a = 1'b0;
        tick(1);
        res_a.ready_i = 1'b0;
        chk("consume_valid", {31'd0, res_a.valid_o}, 32'd0);
    endtask

    task automatic expect_a(input string tag, input logic [3:0] cnt, input logic [1:0] cls);
        chk({tag, "_valid"}, {31'd0, res_a.valid_o}, 32'd1);
        chk({tag, "_count"}, {28'd0, res_a.count_o}, {28'd0, cnt});
        chk({tag, "_class"}, {30'd0, res_a.class_o}, {30'd0, cls});
    endtask

    initial begin
        logic [7:0] pat;

        // Reset with spike toggling, then idle with en low.
        res_a.ready_i = 1'b0;
        res_b.ready_i = 1'b0;
        do_reset();
        chk("rst_valid", {31'd0, res_a.valid_o}, 32'd0);
        chk("rst_count", {28'd0, res_a.count_o}, 32'd0);
        chk("rst_class", {30'd0, res_a.class_o}, 32'd0);
        chk("rst_overrun", {31'd0, res_a.overrun_o}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            spike_i = i[0];
            tick(1);
            chk("idle_valid", {31'd0, res_a.valid_o}, 32'd0);
        end
        spike_i = 1'b0;

        // Basic window: 3 spikes, lo=2 hi=5 -> NORMAL, valid exactly 9 edges after en.
        lo_thr = 4'd2;
        hi_thr = 4'd5;
        start_a();
        pat = 8'b0010_1010;
        for (int i = 0; i < 8; i++) begin
            spike_i = pat[i];
            tick(1);
            if (i < 7) chk("latency_early", {31'd0, res_a.valid_o}, 32'd0);
        end
        spike_i = 1'b0;
        expect_a("basic", 4'd3, 2'd1);
        consume_a();
        tick(2);
        chk("ready_idle_valid", {31'd0, res_a.valid_o}, 32'd0);

        // Level held high a whole window counts once.
        start_a();
        drive_window(8'hFF, 1'b0, 4'd2, 4'd5);
        expect_a("level", 4'd1, 2'd0);
        consume_a();

        // Class boundaries: count 3 with hi=2 -> HIGH, count 3 == lo == hi -> NORMAL.
        start_a();
        drive_window(8'b0010_1010, 1'b0, 4'd2, 4'd2);
        expect_a("cls_high", 4'd3, 2'd2);
        consume_a();
        start_a();
        drive_window(8'b0010_1010, 1'b0, 4'd3, 4'd3);
        expect_a("cls_eq", 4'd3, 2'd1);
        consume_a();

        // Overrun: 1 then 4 spikes with ready low.
        start_a();
        drive_window(8'b0000_0100, 1'b0, 4'd2, 4'd5);
        expect_a("ovr_first", 4'd1, 2'd0);
        chk("ovr_first_flag", {31'd0, res_a.overrun_o}, 32'd0);
        drive_window(8'b0101_0101, 1'b0, 4'd2, 4'd5);
        expect_a("ovr_second", 4'd4, 2'd1);
        chk("ovr_set", {31'd0, res_a.overrun_o}, 32'd1);
        consume_a();
        tick(3);
        chk("ovr_sticky", {31'd0, res_a.overrun_o}, 32'd1);

        // Ready high in the publish cycle: consume-and-reload, no overrun.
        do_reset();
        chk("rst2_overrun", {31'd0, res_a.overrun_o}, 32'd0);
        start_a();
        drive_window(8'b0000_0100, 1'b0, 4'd2, 4'd5);
        drive_window(8'b0001_0100, 1'b1, 4'd2, 4'd5);
        expect_a("rdy_pub", 4'd2, 2'd1);
        chk("rdy_pub_overrun", {31'd0, res_a.overrun_o}, 32'd0);
        consume_a();

        // Abort at window cycle 4 after 2 spikes, then restart with 1 spike.
        start_a();
        pat = 8'b0000_0101;
        for (int i = 0; i < 4; i++) begin
            spike_i = pat[i];
            tick(1);
        end
        spike_i = 1'b0;
        en_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("abort_valid", {31'd0, res_a.valid_o}, 32'd0);
        end
        start_a();
        drive_window(8'b0000_0010, 1'b0, 4'd2, 4'd5);
        expect_a("restart", 4'd1, 2'd0);
        consume_a();

        // Reset mid-window discards the partial count.
        start_a();
        for (int i = 0; i < 4; i++) begin
            spike_i = pat[i];
            tick(1);
        end
        do_reset();
        chk("midrst_valid", {31'd0, res_a.valid_o}, 32'd0);
        tick(10);
        chk("midrst_idle", {31'd0, res_a.valid_o}, 32'd0);
        start_a();
        drive_window(8'b0100_0000, 1'b0, 4'd2, 4'd5);
        expect_a("midrst_restart", 4'd1, 2'd0);
        consume_a();

        // Thresholds matter only in the terminal cycle: inverted pair -> ERROR.
        lo_thr = 4'd0;
        hi_thr = 4'd0;
        start_a();
        drive_window(8'b0000_1010, 1'b0, 4'd6, 4'd3);
        expect_a("cls_err", 4'd2, 2'd3);
        consume_a();

        lo_thr = 4'd0;
        hi_thr = 4'd15;
        start_a();
        drive_window(8'b0010_1010, 1'b0, 4'd4, 4'd10);
        expect_a("cls_low", 4'd3, 2'd0);
        consume_a();

        // An edge in the terminal cycle belongs to the closing window.
        start_a();
        drive_window(8'b1000_0000, 1'b0, 4'd1, 4'd5);
        expect_a("term_edge", 4'd1, 2'd1);
        drive_window(8'b0000_0000, 1'b0, 4'd1, 4'd5);
        expect_a("term_next", 4'd0, 2'd0);
        consume_a();

        // 40-cycle window, 20 edges: saturates at 15 -> HIGH.
        lo_thr = 4'd2;
        hi_thr = 4'd10;
        en_b = 1'b1;
        tick(1);
        for (int i = 0; i < 40; i++) begin
            spike_i = (i % 2 == 0);
            tick(1);
            if (i < 39) chk("sat_early", {31'd0, res_b.valid_o}, 32'd0);
        end
        spike_i = 1'b0;
        en_b = 1'b0;
        chk("sat_valid", {31'd0, res_b.valid_o}, 32'd1);
        chk("sat_count", {28'd0, res_b.count_o}, 32'd15);
        chk("sat_class", {30'd0, res_b.class_o}, 32'd2);
        chk("sat_a_quiet", {31'd0, res_a.valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
